ha_resp_checker: RTL and testbench

HA_RESP_CHECKER -- requirements
Module: ha_resp_checker

---
 rtl/ha_chk_pkg.sv | 19 +
 rtl/ha_golden.sv | 13 +
 rtl/ha_resp_checker.sv | 133 +++++++++++++
 tb/tb_ha_resp_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ha_chk_pkg.sv
// rtl/ha_chk_pkg.sv - shared types and constants for the half-adder response checker
// Counter width, capture width, FSM states and a saturating increment helper.
package ha_chk_pkg;

   localparam int CNT_W = 8;
   localparam int VEC_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ha_golden.sv
// rtl/ha_golden.sv - golden half adder producing the expected sum and carry
// Purely combinational reference against which returned responses are compared.
module ha_golden (
   input  logic i_a,
   input  logic i_b,
   output logic o_sum,
   output logic o_carry
);

   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;

endmodule

// File: rtl/ha_resp_checker.sv
// rtl/ha_resp_checker.sv - run-based response checker for a half adder under test
// Optional operand coverage tracking is built only with HA_CHK_COVERAGE_EN defined.
module ha_resp_checker
   import ha_chk_pkg::*;
#(
   parameter int NUM_VEC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             s,
   input  logic             c,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [VEC_W-1:0] first_fail,
   output logic [VEC_W-1:0] cov_mask
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [CNT_W-1:0] r_pass;
   logic [CNT_W-1:0] r_fail;
   logic [CNT_W-1:0] r_seen;
   logic [VEC_W-1:0] r_first;

   logic w_sum;
   logic w_carry;
   logic w_match;
   logic w_take;
   logic w_launch;

   ha_golden u_golden (
      .i_a     (a),
      .i_b     (b),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   assign w_match  = (s == w_sum) && (c == w_carry);
   assign w_take   = (r_state == RUN) && in_valid;
   assign w_launch = (r_state != RUN) && start;

   // A coincident sample is dropped when a run launches, since the FSM is not yet in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_pass  <= '0;
         r_fail  <= '0;
         r_seen  <= '0;
         r_first <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
                  r_pass  <= '0;
                  r_fail  <= '0;
                  r_seen  <= '0;
                  r_first <= '0;
               end
            end
            RUN: begin
               if (in_valid) begin
                  if (w_match) begin
                     r_pass <= sat_inc(r_pass);
                  end else begin
                     r_fail <= sat_inc(r_fail);
                     r_err  <= 1'b1;
                     if (!r_err) begin
                        r_first <= {a, b, s, c};
                     end
                  end
                  r_seen <= r_seen + 1'b1;
                  if (r_seen == LAST_IDX) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign pass_cnt   = r_pass;
   assign fail_cnt   = r_fail;
   assign first_fail = r_first;

`ifdef HA_CHK_COVERAGE_EN
   logic [VEC_W-1:0] r_cov;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cov <= '0;
      end else if (w_launch) begin
         r_cov <= '0;
      end else if (w_take) begin
         r_cov[{a, b}] <= 1'b1;
      end
   end

   assign cov_mask = r_cov;
`else
   logic w_unused;
   assign w_unused = w_launch ^ w_take;
   assign cov_mask = '0;
`endif

endmodule

// File: tb/tb_ha_resp_checker.sv
// tb/tb_ha_resp_checker.sv - randomized self-checking bench for ha_resp_checker
// Two instances (4 and 255 samples per run) share stimulus and are compared to a run-level model.
module tb_ha_resp_checker;

`ifdef HA_CHK_COVERAGE_EN
   localparam bit COV = 1'b1;
`else
   localparam bit COV = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic start;
   logic in_valid;
   logic a, b, s, c;

   logic [1:0] busy_w;
   logic [1:0] done_w;
   logic [1:0] err_w;
   logic [7:0] pass_w [2];
   logic [7:0] fail_w [2];
   logic [3:0] ff_w   [2];
   logic [3:0] cov_w  [2];

   int n_chk  = 0;
   int n_fail = 0;

   ha_resp_checker #(.NUM_VEC(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .s(s), .c(c),
      .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
      .pass_cnt(pass_w[0]), .fail_cnt(fail_w[0]),
      .first_fail(ff_w[0]), .cov_mask(cov_w[0])
   );

   ha_resp_checker #(.NUM_VEC(255)) u_dut255 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .s(s), .c(c),
      .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
      .pass_cnt(pass_w[1]), .fail_cnt(fail_w[1]),
      .first_fail(ff_w[1]), .cov_mask(cov_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Run-level model: one record per instance, advanced once per rising edge.
   int         m_mode [2];
   int         m_pass [2];
   int         m_fail [2];
   int         m_seen [2];
   bit         m_err  [2];
   bit [3:0]   m_ff   [2];
   bit [3:0]   m_cov  [2];

   function automatic int nv(input int k);
      return (k == 0) ? 4 : 255;
   endfunction

   task automatic model_clear(input int k);
      m_pass[k] = 0; m_fail[k] = 0; m_seen[k] = 0;
      m_err[k]  = 0; m_ff[k]   = 0; m_cov[k]  = 0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0;
         model_clear(k);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_mode[k] = 0;
            model_clear(k);
         end else if (m_mode[k] != 1) begin
            if (start) begin
               m_mode[k] = 1;
               model_clear(k);
            end
         end else if (in_valid) begin
            if (s == (a ^ b) && c == (a & b)) begin
               m_pass[k] = (m_pass[k] < 255) ? m_pass[k] + 1 : 255;
            end else begin
               m_fail[k] = (m_fail[k] < 255) ? m_fail[k] + 1 : 255;
               if (!m_err[k]) m_ff[k] = {a, b, s, c};
               m_err[k] = 1;
            end
            if (COV) m_cov[k][{a, b}] = 1'b1;
            m_seen[k]++;
            if (m_seen[k] == nv(k)) m_mode[k] = 2;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("busy[%0d]", k), busy_w[k], m_mode[k] == 1);
         chk($sformatf("done[%0d]", k), done_w[k], m_mode[k] == 2);
         chk($sformatf("err[%0d]", k), err_w[k], m_err[k]);
         chk($sformatf("pass_cnt[%0d]", k), pass_w[k], m_pass[k]);
         chk($sformatf("fail_cnt[%0d]", k), fail_w[k], m_fail[k]);
         chk($sformatf("first_fail[%0d]", k), ff_w[k], m_ff[k]);
         chk($sformatf("cov_mask[%0d]", k), cov_w[k], m_cov[k]);
      end
   end

   function automatic logic [3:0] good(input logic [1:0] ab);
      return {ab[1], ab[0], ab[1] ^ ab[0], ab[1] & ab[0]};
   endfunction

   task automatic step(input bit st, input bit v, input logic [3:0] abscv);
      start    = st;
      in_valid = v;
      {a, b, s, c} = abscv;
      @(negedge clk);
   endtask

   int  rises;
   bit  prev_done;

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      a = 1'b0; b = 1'b0; s = 1'b0; c = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst busy", busy_w[0], 0);
      chk("rst done", done_w[0], 0);
      chk("rst pass", pass_w[0], 0);
      rst_n = 1'b1;

      // four correct vectors
      step(1, 0, 4'b0);
      step(0, 1, good(2'b00));
      step(0, 1, good(2'b01));
      step(0, 1, good(2'b11));
      step(0, 1, good(2'b10));
      chk("basic done", done_w[0], 1);
      chk("basic pass", pass_w[0], 4);
      chk("basic fail", fail_w[0], 0);
      chk("basic err", err_w[0], 0);
      chk("basic cov", cov_w[0], COV ? 15 : 0);

      // one bad second sample
      step(1, 0, 4'b0);
      step(0, 1, good(2'b00));
      step(0, 1, 4'b1111);
      step(0, 1, good(2'b01));
      step(0, 1, good(2'b10));
      chk("one bad pass", pass_w[0], 3);
      chk("one bad fail", fail_w[0], 1);
      chk("one bad err", err_w[0], 1);
      chk("one bad ff", ff_w[0], 4'b1111);

      // two bad samples, first one captured
      step(1, 0, 4'b0);
      step(0, 1, 4'b1000);
      step(0, 1, 4'b0111);
      step(0, 1, good(2'b11));
      step(0, 1, good(2'b00));
      chk("two bad ff", ff_w[0], 4'b1000);
      chk("two bad fail", fail_w[0], 2);

      // restart from DONE with a coincident (bad) sample
      step(1, 1, 4'b0001);
      chk("restart busy", busy_w[0], 1);
      chk("restart pass", pass_w[0], 0);
      chk("restart fail", fail_w[0], 0);
      chk("restart err", err_w[0], 0);

      for (int i = 0; i < 80; i++) begin
         logic [1:0] ab;
         logic [3:0] smp;
         ab  = 2'($urandom_range(0, 3));
         smp = good(ab);
         if ($urandom_range(0, 4) == 0) smp[1:0] = 2'($urandom_range(0, 3));
         step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, smp);
      end

      // asynchronous reset mid-run, then samples without start
      step(1, 0, 4'b0);
      step(0, 1, good(2'b01));
      step(0, 1, good(2'b10));
      #2 rst_n = 1'b0;
      #1;
      chk("async busy", busy_w[0], 0);
      chk("async pass", pass_w[0], 0);
      chk("async first_fail", ff_w[1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1, good(2'b11));
      step(0, 1, good(2'b01));
      step(0, 1, 4'b1111);
      chk("post rst pass", pass_w[0], 0);
      chk("post rst fail", fail_w[0], 0);
      chk("post rst busy", busy_w[1], 0);

      // full 255-sample run with an ignored start pulse mid-run
      rises = 0;
      prev_done = 1'b0;
      step(1, 0, 4'b0);
      for (int i = 0; i < 258; i++) begin
         step(i == 100, 1, good(2'($urandom_range(0, 3))));
         if (done_w[1] && !prev_done) rises++;
         prev_done = done_w[1];
         if (i == 254) begin
            chk("big pass 255", pass_w[1], 255);
            chk("big done", done_w[1], 1);
         end
      end
      chk("big pass hold", pass_w[1], 255);
      chk("big fail", fail_w[1], 0);
      chk("big done once", rises, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
